imem_loader: RTL and testbench

- Runtime program loader: the write-side counterpart of the byte-addressed, little-endian instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles each group of 4 bytes into a little-endian 32-bit word.
- Issues one word write per 4 bytes into the instruction memory's write port, at consecutive word addresses from a programmed base.
- Sits between the host/test interface and the instruction memory; the CPU is held off while busy is high.

---
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader.sv | 180 ++++++++++++++++++
 tb/tb_imem_loader.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream and instruction-memory write-port bundle for the
// program loader.
//   byte_in/byte_valid/byte_ready : host -> loader byte stream (valid/ready)
//   mem_we/mem_addr/mem_wdata     : loader -> instruction memory write port
// Modports: master = host/memory side, slave = loader side.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: runtime program loader. Packs a little-endian byte stream into
// 32-bit words and writes them to consecutive instruction-memory word
// addresses starting at a word-aligned base.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : load request (sampled in IDLE only)
//   base_addr         : first byte address, low two bits ignored
//   num_words         : number of words to load
//   bus (slave)       : byte stream in, memory write port out
//   busy, done, err   : loading / end-of-load pulse / sticky overflow
//   checksum          : sum of written words (only with IMEM_LOADER_CHECKSUM_EN)
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_BYTES  = 1024,
  parameter int unsigned CNT_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_words,
  imem_loader_if.slave          bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]           checksum
`endif
);

  localparam int unsigned AW1 = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [23:0]           word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic                  err_q, err_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  ovf;
  logic                  unused_base_lsb;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]           csum_q, csum_d;
`endif

  assign unused_base_lsb = ^base_addr[1:0];

  // Widened compare so a wrapping addr + 4 cannot slip under the bound.
  assign ovf = ({1'b0, addr_q} + AW1'(4)) > AW1'(MEM_BYTES);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = mem_we_q ? csum_q + mem_wdata_q : csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = {base_addr[ADDR_WIDTH-1:2], 2'b00};
          rem_d   = num_words;
          err_d   = 1'b0;
          idx_d   = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = 32'd0;
`endif
          state_d = (num_words == CNT_WIDTH'(0)) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        if (bus.byte_valid && byte_ready_q) begin
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0: word_d[7:0]   = bus.byte_in;
            2'd1: word_d[15:8]  = bus.byte_in;
            2'd2: word_d[23:16] = bus.byte_in;
            default: begin
              // Last byte bypasses the assembly register straight into the
              // write data so the strobe lands in the following cycle.
              state_d = S_WRITE;
              if (!ovf) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = addr_q;
                mem_wdata_d = {bus.byte_in, word_q};
              end
            end
          endcase
        end
      end
      S_WRITE: begin
        if (ovf) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(4);
          rem_d   = rem_q - CNT_WIDTH'(1);
          state_d = (rem_q == CNT_WIDTH'(1)) ? S_DONE : S_RECV;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    byte_ready_d = (state_d == S_RECV);
    busy_d       = (state_d == S_RECV) || (state_d == S_WRITE);
    done_d       = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      word_q       <= 24'd0;
      addr_q       <= '0;
      rem_q        <= '0;
      err_q        <= 1'b0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      err_q        <= err_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign checksum       = csum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
module tb_imem_loader;
  localparam int unsigned AW = 32;
  localparam int unsigned CW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] num_words;
  logic          busy, done, err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW), .MEM_BYTES(1024), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .bus       (bus.slave),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int done_cnt = 0;
  int consumed = 0;
  int rdy_in_write = 0;

  // Passive observer of writes, done pulses and byte transfers.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wa_q.push_back(bus.mem_addr);
      wd_q.push_back(bus.mem_wdata);
      if (bus.byte_ready) rdy_in_write++;
    end
    if (done) done_cnt++;
    if (bus.byte_valid && bus.byte_ready) consumed++;
  end

  task automatic clear_obs();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    consumed = 0;
    rdy_in_write = 0;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [CW-1:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_words = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offers one byte until accepted; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int cyc;
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (bus.byte_ready) break;
      cyc++;
      if (cyc > 50) begin
        n_checks++; n_fail++;
        $display("FAIL send_byte timeout: byte %h never accepted", b);
        break;
      end
    end
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  // Returns at the negedge inside the done cycle.
  task automatic wait_done();
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      cyc++;
      if (cyc > 100) begin
        n_checks++; n_fail++;
        $display("FAIL wait_done timeout: done=%b want 1", done);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
    bus.byte_in = 8'h00; bus.byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset_byte_ready: got %b want 0", bus.byte_ready); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++; if (bus.mem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
    rst = 1'b0;
  endtask

  task automatic test_basic_load();
    logic [7:0] w0 [4] = '{8'h13, 8'h00, 8'hA0, 8'hE3};
    logic [7:0] w1 [4] = '{8'h01, 8'h10, 8'h80, 8'hE2};
    clear_obs();
    do_start(32'h0, CW'(2));
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
    for (int i = 0; i < 4; i++) send_byte(w0[i]);
    // Write strobe in the cycle after the 4th byte, ready back one cycle later.
    @(negedge clk);
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL basic_latency_we: got %b want 1", bus.mem_we); end
    n_checks++; if (bus.byte_ready !== 1'b0) begin n_fail++; $display("FAIL basic_write_ready: got %b want 0", bus.byte_ready); end
    @(negedge clk);
    n_checks++; if (bus.byte_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_back: got %b want 1", bus.byte_ready); end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send_byte(w1[i]);
    wait_done();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", err); end
    repeat (3) @(negedge clk);
    n_checks++; if (wa_q.size() !== 2) begin n_fail++; $display("FAIL basic_nwrites: got %0d want 2", wa_q.size()); end
    if (wa_q.size() == 2) begin
      n_checks++; if (wa_q[0] !== 32'h0) begin n_fail++; $display("FAIL basic_addr0: got %h want 00000000", wa_q[0]); end
      n_checks++; if (wd_q[0] !== 32'hE3A00013) begin n_fail++; $display("FAIL basic_data0: got %h want e3a00013", wd_q[0]); end
      n_checks++; if (wa_q[1] !== 32'h4) begin n_fail++; $display("FAIL basic_addr1: got %h want 00000004", wa_q[1]); end
      n_checks++; if (wd_q[1] !== 32'hE2801001) begin n_fail++; $display("FAIL basic_data1: got %h want e2801001", wd_q[1]); end
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
    n_checks++; if (consumed !== 8) begin n_fail++; $display("FAIL basic_consumed: got %0d want 8", consumed); end
    @(posedge clk); #1;
  endtask

  task automatic test_throttled();
    logic [7:0] w [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_obs();
    do_start(32'h10, CW'(1));
    for (int i = 0; i < 4; i++) begin
      send_byte(w[i]);
      @(posedge clk); #1;
    end
    wait_done();
    repeat (3) @(negedge clk);
    n_checks++; if (consumed !== 4) begin n_fail++; $display("FAIL thr_consumed: got %0d want 4", consumed); end
    n_checks++; if (wa_q.size() !== 1) begin n_fail++; $display("FAIL thr_nwrites: got %0d want 1", wa_q.size()); end
    if (wa_q.size() == 1) begin
      n_checks++; if (wa_q[0] !== 32'h10) begin n_fail++; $display("FAIL thr_addr: got %h want 00000010", wa_q[0]); end
      n_checks++; if (wd_q[0] !== 32'h44332211) begin n_fail++; $display("FAIL thr_data: got %h want 44332211", wd_q[0]); end
    end
    n_checks++; if (rdy_in_write !== 0) begin n_fail++; $display("FAIL thr_ready_in_write: got %0d want 0", rdy_in_write); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    clear_obs();
    do_start(32'h3FE, CW'(2));
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1));
    wait_done();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err_at_done: got %b want 1", err); end
    repeat (3) @(negedge clk);
    n_checks++; if (wa_q.size() !== 1) begin n_fail++; $display("FAIL ovf_nwrites: got %0d want 1", wa_q.size()); end
    if (wa_q.size() == 1) begin
      n_checks++; if (wa_q[0] !== 32'h3FC) begin n_fail++; $display("FAIL ovf_addr0: got %h want 000003fc", wa_q[0]); end
      n_checks++; if (wd_q[0] !== 32'h04030201) begin n_fail++; $display("FAIL ovf_data0: got %h want 04030201", wd_q[0]); end
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ovf_done_cnt: got %0d want 1", done_cnt); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err_sticky: got %b want 1", err); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_words();
    clear_obs();
    do_start(32'h0, CW'(0));
    @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", done); end
    n_checks++; if (bus.byte_ready !== 1'b0) begin n_fail++; $display("FAIL zero_ready: got %b want 0", bus.byte_ready); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL zero_err_cleared: got %b want 0", err); end
    bus.byte_valid = 1'b1;
    repeat (4) @(negedge clk);
    bus.byte_valid = 1'b0;
    n_checks++; if (wa_q.size() !== 0) begin n_fail++; $display("FAIL zero_nwrites: got %0d want 0", wa_q.size()); end
    n_checks++; if (consumed !== 0) begin n_fail++; $display("FAIL zero_consumed: got %0d want 0", consumed); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    clear_obs();
    do_start(32'h40, CW'(1));
    send_byte(8'h55);
    send_byte(8'h66);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_checks++; if (bus.byte_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b want 0", bus.byte_ready); end
    repeat (4) @(negedge clk);
    n_checks++; if (wa_q.size() !== 0) begin n_fail++; $display("FAIL rstmid_nwrites: got %0d want 0", wa_q.size()); end
    @(posedge clk); #1;
    clear_obs();
    do_start(32'h20, CW'(1));
    for (int i = 0; i < 4; i++) send_byte(w[i]);
    wait_done();
    repeat (2) @(negedge clk);
    n_checks++; if (wa_q.size() !== 1) begin n_fail++; $display("FAIL rstmid_reload_nwrites: got %0d want 1", wa_q.size()); end
    if (wa_q.size() == 1) begin
      n_checks++; if (wa_q[0] !== 32'h20) begin n_fail++; $display("FAIL rstmid_addr: got %h want 00000020", wa_q[0]); end
      n_checks++; if (wd_q[0] !== 32'hDDCCBBAA) begin n_fail++; $display("FAIL rstmid_data: got %h want ddccbbaa", wd_q[0]); end
    end
    @(posedge clk); #1;
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] b [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    clear_obs();
    do_start(32'h100, CW'(2));
    n_checks++; if (checksum !== 32'd0) begin n_fail++; $display("FAIL csum_cleared: got %h want 00000000", checksum); end
    for (int i = 0; i < 8; i++) send_byte(b[i]);
    wait_done();
    n_checks++; if (checksum !== 32'h00000001) begin n_fail++; $display("FAIL csum_final: got %h want 00000001", checksum); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_throttled();
    test_overflow();
    test_zero_words();
    test_reset_mid_word();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
